// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling at a runtime divisor, stop sample at half+9*cpb after detection.
// Result pulses one cycle after the stop sample; the downstream FIFO never backpressures, so a full FIFO yields an overrun pulse.
module uart_rx_core (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_en_i,
  input  logic [15:0] clks_per_bit_i,
  input  logic        rx_i,
  input  logic        fifo_full_i,
  output logic [7:0]  data_o,
  output logic        wr_en_o,
  output logic        frame_err_o,
  output logic        overrun_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e      state_q;
  logic        s1_q, s2_q, s3_q;
  logic [15:0] cpb_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shreg_q;
  logic [7:0]  data_q;
  logic        wr_en_q, frame_err_q, overrun_q;

  logic        fall;
  logic [15:0] half;
  logic [15:0] cnt_inc;

  assign fall    = s3_q & ~s2_q;
  assign half    = cpb_q >> 1;
  assign cnt_inc = cnt_q + 16'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      s3_q        <= 1'b1;
      cpb_q       <= 16'd0;
      cnt_q       <= 16'd0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      data_q      <= 8'h00;
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      s1_q        <= rx_i;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Disabling mid-frame silently drops the partial byte.
      if (state_q != IDLE && !rx_en_i) begin
        state_q   <= IDLE;
        cnt_q     <= 16'd0;
        bit_idx_q <= 3'd0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            if (rx_en_i && fall) begin
              state_q <= START;
              cpb_q   <= clks_per_bit_i;
            end
          end
          START: begin
            if (cnt_q == half - 16'd1) begin
              cnt_q   <= 16'd0;
              state_q <= s2_q ? IDLE : DATA;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          DATA: begin
            if (cnt_q == cpb_q - 16'd1) begin
              shreg_q   <= {s2_q, shreg_q[7:1]};
              cnt_q     <= 16'd0;
              bit_idx_q <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) begin
                state_q   <= STOP;
                bit_idx_q <= 3'd0;
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          STOP: begin
            if (cnt_q == cpb_q - 16'd1) begin
              state_q <= IDLE;
              cnt_q   <= 16'd0;
              if (!s2_q) begin
                frame_err_q <= 1'b1;
              end else if (fifo_full_i) begin
                overrun_q <= 1'b1;
              end else begin
                wr_en_q <= 1'b1;
                data_q  <= shreg_q;
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign data_o      = data_q;
  assign wr_en_o     = wr_en_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive engine of the UART peripheral. It oversamples the asynchronous `rx_i` line with a programmable clocks-per-bit divisor and deserialises 8N1 frames (start bit, 8 data bits LSB first, 1 stop bit). Each good byte is written to the receive FIFO directly downstream through a one-cycle write strobe. Framing errors, overruns and glitched start bits are flagged and never written.

## Interface
- No parameters. Frame format is fixed at 8N1 and the divisor is a runtime port.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `rx_en_i`  in  1  receiver enable. When low the block stays in IDLE.
- `clks_per_bit_i`  in  16  clock cycles per bit period. Legal range 4..65535. Sampled at start-bit detection and held for the whole frame.
- `rx_i`  in  1  serial line, asynchronous, idle high.
- `fifo_full_i`  in  1  full flag from the receive FIFO.
- `data_o`  out  8  received byte. Drives the FIFO data input.
- `wr_en_o`  out  1  one-cycle write strobe to the FIFO. `data_o` is valid while it is high.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_o`  out  1  one-cycle pulse: good byte dropped because the FIFO was full.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- Synchroniser: `rx_i` passes through 2 flops (`s1`, `s2`). Both reset to 1.
- Edge detect: a third flop `s3` holds the previous `s2`. A falling edge is `s3 & ~s2`.
- Divisor: on the detection cycle, `clks_per_bit_i` is latched into `cpb_q`. `half = cpb_q >> 1`.
- Counters: 16-bit `cnt` and 3-bit `bit_idx`. Both clear on every state transition.
- FSM states and transitions:
  - IDLE: on falling edge with `rx_en_i` high, go to START with `cnt = 0`.
  - START: increment `cnt`. When `cnt == half-1`, sample `s2`. If 0, go to DATA. If 1, treat it as a glitch and return to IDLE with no flags.
  - DATA: increment `cnt`. When `cnt == cpb_q-1`, shift `s2` into `shreg[7]` (right shift, so LSB first), set `cnt = 0` and increment `bit_idx`. After `bit_idx == 7` is sampled, go to STOP.
  - STOP: when `cnt == cpb_q-1`, sample `s2`, then go to IDLE.
    - `s2 == 1` and `fifo_full_i == 0`: next cycle `wr_en_o = 1` and `data_o = shreg`.
    - `s2 == 1` and `fifo_full_i == 1`: next cycle `overrun_o = 1`, no write.
    - `s2 == 0`: next cycle `frame_err_o = 1`, no write. The line must return high before a new edge can be detected; this falls out of the edge detector.
- `fifo_full_i` is evaluated only in the stop-sample cycle.
- `data_o` holds its last written value between strobes.
- `rx_en_i` falling mid-frame: the FSM returns to IDLE on the next edge. The partial byte is discarded and no pulses are issued.
- Reset mid-frame: all state clears immediately. The next valid start edge after reset release is received normally.

## Timing
- Reset values:
  - `data_o = 8'h00`
  - `wr_en_o = 0`, `frame_err_o = 0`, `overrun_o = 0`, `busy_o = 0`
  - FSM in IDLE; `cnt`, `bit_idx`, `shreg` = 0
  - `s1`, `s2`, `s3` = 1
- Detection latency: 2–3 clocks from the `rx_i` fall, due to the synchroniser.
- Start sample: `half` cycles after the detection cycle.
- Each data sample: `cpb_q` cycles after the previous sample, i.e. mid-bit.
- Stop sample: `half + 9*cpb_q` cycles after detection.
- Output pulse: 1 cycle after the stop sample, exactly one cycle wide.
- Pulse exclusivity: at most one of `wr_en_o`, `frame_err_o`, `overrun_o` is high in any cycle.
- Back-to-back frames: a start edge arriving in the same cycle as the output pulse is detected. There is no dead cycle beyond the synchroniser.
- Downstream: the FIFO accepts `wr_en_o` without backpressure. The block never holds data waiting for space.

## Test plan
- Single good byte, `clks_per_bit_i = 16`: send 0xA5, bits 1,0,1,0,0,1,0,1 LSB first, then a high stop bit. Required: exactly one `wr_en_o` pulse with `data_o = 8'hA5`; no error pulses; `busy_o` low afterwards.
- Glitch rejection, `cpb = 16`: drive `rx_i` low for 3 cycles, then high. Required: FSM returns to IDLE after the start sample; no pulses of any kind.
- Framing error: send 0x3C with the stop bit low, then release the line. Required: one `frame_err_o` pulse, no `wr_en_o`. A following 0x5A is received correctly.
- Overrun: hold `fifo_full_i = 1`, send 0x55. Required: one `overrun_o` pulse, no `wr_en_o`. With `fifo_full_i = 0`, the next 0x55 is written.
- Back-to-back frames at `cpb = 4` (minimum divisor): send 0x00 then 0xFF with no idle gap. Required: two `wr_en_o` pulses carrying 0x00 and 0xFF, in order.
- Reset and disable mid-frame:
  - Assert `rst_ni` low during data bit 4. Required: all outputs return to reset values at once; the next 0x81 is received correctly.
  - Drop `rx_en_i` mid-frame. Required: no pulse for that frame.
